// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush controller for the dual-issue 5-stage pipeline.
//
// Sequences the fixed-latency divider and merges the hazard sources into the per-stage
// stall/flush enables. Hazard priority, high to low: WB CSR flush, divider/dcache stall,
// EX branch correction, ID load-use interlock. A saturating counter records stall cycles.
//
// Ports:
//   i_clk, i_rst        clock (rising edge), asynchronous active-high reset
//   i_ex_div_valid      EX slot A holds a div/mod instruction that has not yet been started
//   i_dcache_miss       dcache busy this cycle
//   i_ex_br_a/b         slot A/B mispredict resolved in EX
//   i_id_load_use       ID instruction depends on the load currently in EX
//   i_wb_flush_csr      exception/ertn/CSR flush from WB
//   o_div_start         one-cycle divider launch pulse
//   o_div_cancel        one-cycle divider abort pulse
//   o_stall_div         divider stall to the pipeline registers
//   o_stall_dcache      dcache stall to the pipeline registers
//   o_stall_if          hold PC/IF
//   o_stall_id          hold IF->ID register
//   o_flush_if          clear IF->ID register
//   o_flush_id          insert bubble into ID->EX register
//   o_kill_ex_b         drop slot B in EX->MEM
//   o_flush_all         clear all stage registers
//   o_div_busy          divider sequence in progress
//   o_perf_stall_cnt    saturating count of stall cycles
module pipe_hazard_ctrl #(
    parameter int unsigned DIV_LAT = 33,
    parameter int unsigned PERF_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ex_div_valid,
    input  logic              i_dcache_miss,
    input  logic              i_ex_br_a,
    input  logic              i_ex_br_b,
    input  logic              i_id_load_use,
    input  logic              i_wb_flush_csr,
    output logic              o_div_start,
    output logic              o_div_cancel,
    output logic              o_stall_div,
    output logic              o_stall_dcache,
    output logic              o_stall_if,
    output logic              o_stall_id,
    output logic              o_flush_if,
    output logic              o_flush_id,
    output logic              o_kill_ex_b,
    output logic              o_flush_all,
    output logic              o_div_busy,
    output logic [PERF_W-1:0] o_perf_stall_cnt
);

    localparam int unsigned CNT_W = 6;

    typedef enum logic [0:0] {StRun, StDiv} state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_div_cnt;
    logic [CNT_W-1:0]   w_div_cnt_nxt;
    logic [PERF_W-1:0]  r_perf_cnt;

    logic w_div_go;
    logic w_stall_any;
    logic w_branch;
    logic w_perf_inc;

    // Launch is blocked by a WB flush: the EX instruction is being discarded.
    assign w_div_go = (r_state == StRun) && i_ex_div_valid && !i_wb_flush_csr;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= StRun;
            r_div_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_div_cnt_nxt = r_div_cnt;
        unique case (r_state)
            StRun: begin
                if (w_div_go) begin
                    w_state_nxt   = StDiv;
                    w_div_cnt_nxt = CNT_W'(DIV_LAT - 1);
                end
            end
            StDiv: begin
                // Counter runs through dcache misses; only a WB flush aborts it.
                if (i_wb_flush_csr || (r_div_cnt == '0)) begin
                    w_state_nxt   = StRun;
                    w_div_cnt_nxt = '0;
                end else begin
                    w_div_cnt_nxt = r_div_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt   = StRun;
                w_div_cnt_nxt = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        o_div_start    = w_div_go;
        o_div_cancel   = (r_state == StDiv) && i_wb_flush_csr;
        o_div_busy     = (r_state == StDiv);
        // Quotient is valid on the counter==0 cycle, so EX is released there.
        o_stall_div    = !i_wb_flush_csr &&
                         (w_div_go || ((r_state == StDiv) && (r_div_cnt != '0)));
        o_stall_dcache = i_dcache_miss && !i_wb_flush_csr;
        w_stall_any    = o_stall_div || o_stall_dcache;
        w_branch       = i_ex_br_a || i_ex_br_b;

        o_flush_all    = i_wb_flush_csr;
        o_flush_if     = 1'b0;
        o_flush_id     = 1'b0;
        o_kill_ex_b    = 1'b0;
        o_stall_if     = 1'b0;
        o_stall_id     = 1'b0;

        if (i_wb_flush_csr) begin
            o_flush_if = 1'b1;
            o_flush_id = 1'b1;
        end else if (w_stall_any) begin
            // Branch and load-use wait: their EX/ID inputs are held stable by the stall.
            o_stall_if = 1'b1;
            o_stall_id = 1'b1;
        end else if (w_branch) begin
            o_flush_if  = 1'b1;
            o_flush_id  = 1'b1;
            o_kill_ex_b = i_ex_br_a;
        end else if (i_id_load_use) begin
            o_stall_if = 1'b1;
            o_stall_id = 1'b1;
            o_flush_id = 1'b1;
        end
    end

    assign w_perf_inc = w_stall_any || i_id_load_use;

    // Saturating stall-cycle counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_perf_cnt <= '0;
        end else if (w_perf_inc && (r_perf_cnt != {PERF_W{1'b1}})) begin
            r_perf_cnt <= r_perf_cnt + 1'b1;
        end
    end

    assign o_perf_stall_cnt = r_perf_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl.
// A second instance with a 4-bit performance counter shares the stimulus to show saturation.
module tb_pipe_hazard_ctrl;

    logic i_clk;
    logic i_rst;
    logic i_ex_div_valid;
    logic i_dcache_miss;
    logic i_ex_br_a;
    logic i_ex_br_b;
    logic i_id_load_use;
    logic i_wb_flush_csr;

    logic o_div_start, o_div_cancel, o_stall_div, o_stall_dcache, o_stall_if, o_stall_id;
    logic o_flush_if, o_flush_id, o_kill_ex_b, o_flush_all, o_div_busy;
    logic [31:0] o_perf_stall_cnt;

    logic s_div_start, s_div_cancel, s_stall_div, s_stall_dcache, s_stall_if, s_stall_id;
    logic s_flush_if, s_flush_id, s_kill_ex_b, s_flush_all, s_div_busy;
    logic [3:0] s_perf_stall_cnt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    pipe_hazard_ctrl #(.DIV_LAT(33), .PERF_W(32)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_ex_div_valid   (i_ex_div_valid),
        .i_dcache_miss    (i_dcache_miss),
        .i_ex_br_a        (i_ex_br_a),
        .i_ex_br_b        (i_ex_br_b),
        .i_id_load_use    (i_id_load_use),
        .i_wb_flush_csr   (i_wb_flush_csr),
        .o_div_start      (o_div_start),
        .o_div_cancel     (o_div_cancel),
        .o_stall_div      (o_stall_div),
        .o_stall_dcache   (o_stall_dcache),
        .o_stall_if       (o_stall_if),
        .o_stall_id       (o_stall_id),
        .o_flush_if       (o_flush_if),
        .o_flush_id       (o_flush_id),
        .o_kill_ex_b      (o_kill_ex_b),
        .o_flush_all      (o_flush_all),
        .o_div_busy       (o_div_busy),
        .o_perf_stall_cnt (o_perf_stall_cnt)
    );

    pipe_hazard_ctrl #(.DIV_LAT(33), .PERF_W(4)) dut_sat (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_ex_div_valid   (i_ex_div_valid),
        .i_dcache_miss    (i_dcache_miss),
        .i_ex_br_a        (i_ex_br_a),
        .i_ex_br_b        (i_ex_br_b),
        .i_id_load_use    (i_id_load_use),
        .i_wb_flush_csr   (i_wb_flush_csr),
        .o_div_start      (s_div_start),
        .o_div_cancel     (s_div_cancel),
        .o_stall_div      (s_stall_div),
        .o_stall_dcache   (s_stall_dcache),
        .o_stall_if       (s_stall_if),
        .o_stall_id       (s_stall_id),
        .o_flush_if       (s_flush_if),
        .o_flush_id       (s_flush_id),
        .o_kill_ex_b      (s_kill_ex_b),
        .o_flush_all      (s_flush_all),
        .o_div_busy       (s_div_busy),
        .o_perf_stall_cnt (s_perf_stall_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output vector order:
    // start cancel stall_div stall_dcache stall_if stall_id flush_if flush_id kill_b flush_all busy
    function automatic logic [10:0] outs();
        return {o_div_start, o_div_cancel, o_stall_div, o_stall_dcache, o_stall_if, o_stall_id,
                o_flush_if, o_flush_id, o_kill_ex_b, o_flush_all, o_div_busy};
    endfunction

    function automatic logic [10:0] ev(input bit start, input bit cancel, input bit sdiv,
                                       input bit sdc, input bit sif, input bit sid,
                                       input bit fif, input bit fid, input bit kill,
                                       input bit fall, input bit busy);
        return {start, cancel, sdiv, sdc, sif, sid, fif, fid, kill, fall, busy};
    endfunction

    // Apply inputs shortly after a rising edge and let the combinational outputs settle.
    task automatic drive(input bit dv, input bit miss, input bit bra, input bit brb,
                         input bit lu, input bit fl);
        i_ex_div_valid = dv;
        i_dcache_miss  = miss;
        i_ex_br_a      = bra;
        i_ex_br_b      = brb;
        i_id_load_use  = lu;
        i_wb_flush_csr = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        check("reset_outs", 64'(outs()), 64'(ev(0,0,0,0,0,0,0,0,0,0,0)));
        check("reset_perf", 64'(o_perf_stall_cnt), 64'd0);
        tick();
        tick();
        i_rst = 1'b0;
        tick();

        // Load-use alone: one-cycle bubble.
        drive(0, 0, 0, 0, 1, 0);
        check("lu_outs", 64'(outs()), 64'(ev(0,0,0,0,1,1,0,1,0,0,0)));
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("lu_after", 64'(outs()), 64'(ev(0,0,0,0,0,0,0,0,0,0,0)));
        check("lu_perf", 64'(o_perf_stall_cnt), 64'd1);
        check("lu_perf_sat", 64'(s_perf_stall_cnt), 64'd1);

        // Full divide: start at t0, stall t0..t32, busy t1..t33.
        drive(1, 0, 0, 0, 0, 0);
        check("div_t0", 64'(outs()), 64'(ev(1,0,1,0,1,1,0,0,0,0,0)));
        tick();
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 32; k++) begin
            check($sformatf("div_t%0d", k), 64'(outs()), 64'(ev(0,0,1,0,1,1,0,0,0,0,1)));
            tick();
        end
        check("div_t33", 64'(outs()), 64'(ev(0,0,0,0,0,0,0,0,0,0,1)));
        tick();
        check("div_t34", 64'(outs()), 64'(ev(0,0,0,0,0,0,0,0,0,0,0)));
        check("div_perf", 64'(o_perf_stall_cnt), 64'd34);
        check("div_perf_sat", 64'(s_perf_stall_cnt), 64'd15);

        // Cancel on the 5th stall cycle.
        drive(1, 0, 0, 0, 0, 0);
        check("cxl_s0", 64'(outs()), 64'(ev(1,0,1,0,1,1,0,0,0,0,0)));
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        tick();
        drive(0, 0, 0, 0, 0, 1);
        check("cxl_s4", 64'(outs()), 64'(ev(0,1,0,0,0,0,1,1,0,1,1)));
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("cxl_after", 64'(outs()), 64'(ev(0,0,0,0,0,0,0,0,0,0,0)));
        check("cxl_perf", 64'(o_perf_stall_cnt), 64'd38);

        // Dcache miss holds a pending branch for 4 cycles.
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 1, 0, 0, 0);
            check($sformatf("miss_br_c%0d", k), 64'(outs()), 64'(ev(0,0,0,1,1,1,0,0,0,0,0)));
            tick();
        end
        drive(0, 0, 1, 0, 0, 0);
        check("miss_br_c4", 64'(outs()), 64'(ev(0,0,0,0,0,0,1,1,1,0,0)));
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("miss_br_c5", 64'(outs()), 64'(ev(0,0,0,0,0,0,0,0,0,0,0)));
        check("miss_perf", 64'(o_perf_stall_cnt), 64'd42);

        // Slot B branch overrides load-use.
        drive(0, 0, 0, 1, 1, 0);
        check("brb_lu", 64'(outs()), 64'(ev(0,0,0,0,0,0,1,1,0,0,0)));
        tick();

        // Flush in RUN blocks a divider launch and any stall.
        drive(1, 1, 0, 0, 0, 1);
        check("flush_run", 64'(outs()), 64'(ev(0,0,0,0,0,0,1,1,0,1,0)));
        tick();

        // Divide and dcache miss together, then reset mid-divide.
        drive(1, 1, 0, 0, 0, 0);
        check("div_miss_t0", 64'(outs()), 64'(ev(1,0,1,1,1,1,0,0,0,0,0)));
        tick();
        drive(0, 1, 0, 0, 0, 0);
        check("div_miss_t1", 64'(outs()), 64'(ev(0,0,1,1,1,1,0,0,0,0,1)));
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("div_t2_busy", 64'(o_div_busy), 64'd1);
        #2;
        i_rst = 1'b1;
        #1;
        check("rst_mid_outs", 64'(outs()), 64'(ev(0,0,0,0,0,0,0,0,0,0,0)));
        check("rst_mid_perf", 64'(o_perf_stall_cnt), 64'd0);
        tick();
        i_rst = 1'b0;
        tick();
        check("post_rst_outs", 64'(outs()), 64'(ev(0,0,0,0,0,0,0,0,0,0,0)));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
